// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, FSM state and NZCV bit-index definitions shared by alu_mc
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_ORR = 3'b011,
        OP_EOR = 3'b100,
        OP_LSL = 3'b101,
        OP_LSR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - shift-add multiplier, one bit of b per cycle, WIDTH cycles per product
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               active;

    // Bit 0 of b is consumed on the start edge so the product completes after WIDTH edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand  <= {{WIDTH{1'b0}}, a} << 1;
            mplier <= b >> 1;
            cnt    <= CW'(WIDTH - 1);
            active <= 1'b1;
        end else if (active) begin
            if (cnt != '0) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
            end else begin
                active <= 1'b0;
            end
        end
    end

    assign done    = active && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - handshaked multi-cycle ALU with NZCV register; ALU_MUL_EN selects iterative MUL, else opcode 111 is ASR
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       alu_control,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       res_flags,
    output logic [3:0]       flags,
    output logic             busy
);
    state_e             state;
    logic               keep_flags;
    logic [WIDTH-1:0]   res;
    logic               c;
    logic               v;
    logic [3:0]         nzcv;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = src_b[SHAMT_W-1:0];

`ifndef ALU_MUL_EN
    logic signed [WIDTH:0] asr_src;
    assign asr_src = {src_a, 1'b0};
`endif

    // Shifts carry an extra bit below/above the word so C falls out as the last bit shifted out.
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (alu_op_e'(alu_control))
            OP_ADD: begin
                {c, res} = {1'b0, src_a} + {1'b0, src_b};
                v = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (res[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                {c, res} = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
                v = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (res[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND: res = src_a & src_b;
            OP_ORR: res = src_a | src_b;
            OP_EOR: res = src_a ^ src_b;
            OP_LSL: {c, res} = {1'b0, src_a} << shamt;
            OP_LSR: {res, c} = {src_a, 1'b0} >> shamt;
`ifdef ALU_MUL_EN
            default: ;
`else
            default: {res, c} = asr_src >>> shamt;
`endif
        endcase
    end

    always_comb begin
        nzcv         = '0;
        nzcv[FLAG_N] = res[WIDTH-1];
        nzcv[FLAG_Z] = ~|res;
        nzcv[FLAG_C] = c;
        nzcv[FLAG_V] = v;
    end

`ifdef ALU_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic               busy_q;
    logic [2*WIDTH-1:0] product;
    logic [3:0]         mul_nzcv;

    assign mul_start = (state == IDLE) && in_valid && (alu_control == OP_MUL);
    assign busy      = busy_q;

    always_comb begin
        mul_nzcv         = '0;
        mul_nzcv[FLAG_N] = product[WIDTH-1];
        mul_nzcv[FLAG_Z] = ~|product[WIDTH-1:0];
        mul_nzcv[FLAG_C] = |product[2*WIDTH-1:WIDTH];
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (src_a),
        .b       (src_b),
        .done    (mul_done),
        .product (product)
    );
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            alu_result <= '0;
            res_flags  <= '0;
            flags      <= '0;
            keep_flags <= 1'b0;
`ifdef ALU_MUL_EN
            busy_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    keep_flags <= set_flags;
                    in_ready   <= 1'b0;
`ifdef ALU_MUL_EN
                    if (alu_control == OP_MUL) begin
                        state  <= MUL;
                        busy_q <= 1'b1;
                    end else
`endif
                    begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        alu_result <= res;
                        res_flags  <= nzcv;
                    end
                end
`ifdef ALU_MUL_EN
                MUL: if (mul_done) begin
                    state      <= DONE;
                    busy_q     <= 1'b0;
                    out_valid  <= 1'b1;
                    alu_result <= product[WIDTH-1:0];
                    res_flags  <= mul_nzcv;
                end
`endif
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    if (keep_flags) begin
                        flags <= res_flags;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized self-checking bench for alu_mc against a behavioural model
`timescale 1ns/1ps
module tb_alu_mc;
    localparam int W = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic [2:0]   alu_control = '0;
    logic         set_flags = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] alu_result;
    logic [3:0]   res_flags;
    logic [3:0]   flags;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (alu_control),
        .set_flags   (set_flags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .res_flags   (res_flags),
        .flags       (flags),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {N,Z,C,V, result} computed from plain integer arithmetic.
    function automatic logic [35:0] model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0]  wide;
        logic [W-1:0] r;
        longint       sr;
        bit           c;
        bit           v;
        int           s;
        s = int'(b[4:0]);
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            3'd0: begin
                wide = {32'b0, a} + {32'b0, b};
                r = wide[31:0];
                c = wide[32];
                sr = longint'($signed(a)) + longint'($signed(b));
                v = (sr != longint'($signed(r)));
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                sr = longint'($signed(a)) - longint'($signed(b));
                v = (sr != longint'($signed(r)));
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                wide = {32'b0, a} << s;
                r = wide[31:0];
                c = (s != 0) && wide[32];
            end
            3'd6: begin
                r = a >> s;
                c = (s != 0) && a[s-1];
            end
            default: begin
                if (MUL_EN) begin
                    wide = {32'b0, a} * {32'b0, b};
                    r = wide[31:0];
                    c = |wide[63:32];
                end else begin
                    r = $signed(a) >>> s;
                    c = (s != 0) && a[s-1];
                end
            end
        endcase
        return {r[W-1], (r == '0), c, v, r};
    endfunction

    bit           m_idle = 1'b1;
    bit           m_done = 1'b0;
    bit           m_setf = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_pres = '0;
    logic [3:0]   m_rf = '0;
    logic [3:0]   m_prf = '0;
    logic [3:0]   m_flags = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_idle = 1'b1;
            m_done = 1'b0;
            m_left = 0;
            m_res = '0;
            m_rf = '0;
            m_flags = '0;
        end else if (m_idle) begin
            if (in_valid) begin
                {m_prf, m_pres} = model_op(alu_control, src_a, src_b);
                m_setf = set_flags;
                m_idle = 1'b0;
                m_left = (MUL_EN && alu_control == 3'b111) ? MUL_LAT - 1 : 0;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_res = m_pres;
                    m_rf = m_prf;
                end
            end
        end else if (!m_done) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_res = m_pres;
                m_rf = m_prf;
            end
        end else if (out_ready) begin
            m_done = 1'b0;
            m_idle = 1'b1;
            if (m_setf) m_flags = m_rf;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_idle);
        chk("out_valid", out_valid, m_done);
        chk("busy", busy, !m_idle && !m_done);
        chk("alu_result", alu_result, m_res);
        chk("res_flags", res_flags, m_rf);
        chk("flags", flags, m_flags);
    end

    task automatic scramble_inputs();
        in_valid = 1'($urandom_range(0, 1));
        alu_control = 3'($urandom);
        src_a = $urandom;
        src_b = $urandom;
        set_flags = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit sf, input int hold, input bit lit,
                          input logic [W-1:0] er, input logic [3:0] ef, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk({tag, "_ready_timeout"}, in_ready, 1);
        in_valid = 1'b1;
        alu_control = op;
        src_a = a;
        src_b = b;
        set_flags = sf;
        out_ready = 1'b0;
        @(posedge clk); #1;
        n = 1;
        while (!out_valid && n < MUL_LAT + 4) begin
            scramble_inputs();
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        if (!out_valid) chk({tag, "_out_valid_timeout"}, out_valid, 1);
        if (lit) begin
            chk({tag, "_latency"}, n, (MUL_EN && op == 3'b111) ? MUL_LAT : 1);
            chk({tag, "_result"}, alu_result, er);
            chk({tag, "_res_flags"}, res_flags, ef);
        end
        repeat (hold) begin
            scramble_inputs();
            @(posedge clk); #1;
        end
        if (lit && hold > 0) begin
            chk({tag, "_held_result"}, alu_result, er);
            chk({tag, "_held_in_ready"}, in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7fff_ffff;
            4: return W'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_result", alu_result, 0);
        chk("reset_res_flags", res_flags, 0);
        chk("reset_flags", flags, 0);

        chk("pin_add", model_op(3'd0, 4, 5), {4'b0000, 32'd9});
        chk("pin_sub_neg", model_op(3'd1, 4, 5), {4'b1000, 32'hffff_ffff});
        chk("pin_add_ovf", model_op(3'd0, 32'h7fff_ffff, 1), {4'b1001, 32'h8000_0000});
        chk("pin_lsr", model_op(3'd6, 32'h3, 1), {4'b0010, 32'h1});

        run_op(3'd0, 4, 5, 1'b1, 0, 1'b1, 32'd9, 4'b0000, "add_4_5");
        chk("flags_after_add", flags, 4'b0000);

`ifdef ALU_MUL_EN
        in_valid = 1'b1;
        alu_control = 3'b111;
        src_a = 32'h0000_1234;
        src_b = 32'h0000_ffff;
        set_flags = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_mul_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("rst_mul_out_valid", out_valid, 0);
        chk("rst_mul_busy", busy, 0);
        chk("rst_mul_in_ready", in_ready, 1);
        chk("rst_mul_flags", flags, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op(3'd0, 1, 1, 1'b1, 0, 1'b1, 32'd2, 4'b0000, "add_after_rst");
`endif

        run_op(3'd1, 4, 5, 1'b0, 0, 1'b1, 32'hffff_ffff, 4'b1000, "sub_4_5");
        chk("flags_no_set", flags, 4'b0000);
        run_op(3'd1, 5, 5, 1'b1, 0, 1'b1, 32'h0, 4'b0110, "sub_5_5");
        chk("flags_set_sub", flags, 4'b0110);
        run_op(3'd0, 32'h7fff_ffff, 1, 1'b0, 0, 1'b1, 32'h8000_0000, 4'b1001, "add_ovf");
        run_op(3'd5, 32'h8000_0001, 1, 1'b0, 0, 1'b1, 32'h0000_0002, 4'b0010, "lsl_1");
`ifdef ALU_MUL_EN
        run_op(3'd7, 32'h0001_0000, 32'h0001_0000, 1'b1, 0, 1'b1, 32'h0, 4'b0110, "mul_2p32");
        run_op(3'd7, 32'h1234_5678, 0, 1'b0, 0, 1'b1, 32'h0, 4'b0100, "mul_by_0");
`else
        run_op(3'd7, 32'h8000_0000, 4, 1'b1, 0, 1'b1, 32'hf800_0000, 4'b1000, "asr_4");
`endif
        run_op(3'd0, 3, 3, 1'b0, 10, 1'b1, 32'd6, 4'b0000, "add_backpressure");

        for (int i = 0; i < 200; i++) begin
            run_op(3'($urandom), pick(), pick(), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'b0, '0, '0, "rnd");
        end

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
